// File: rtl/ifu_fetch_pkg.sv
// Shared definitions for the instruction fetch unit and the decoder that consumes
// its output: fetch FSM states, reset vector, NOP encoding and base opcodes.
package ifu_fetch_pkg;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_REQ,
    ST_WAIT,
    ST_OUT,
    ST_DROP
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RST_VECTOR = 32'h8000_0000;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = {12'h000, 5'd0, 3'b000, 5'd0, OPC_OP_IMM};

  function automatic logic word_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, keeps at most one instruction-memory request
// in flight, and presents fetched words to decode over a valid/ready handshake.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [31:0] RST_VECTOR = DEFAULT_RST_VECTOR,
  parameter int          XLEN       = 32
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  input  logic            imem_resp_err,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_instr,
  output logic            id_fault,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt,
  output logic [31:0]     fetch_cnt
);

  fetch_state_e    state_q;
  logic [XLEN-1:0] pc_q;
  logic            id_valid_q;
  logic [XLEN-1:0] id_pc_q;
  logic [XLEN-1:0] id_instr_q;
  logic            id_fault_q;
  logic [31:0]     cnt_q;

  logic pc_aligned;
  logic req_fire;

  assign pc_aligned     = word_aligned(pc_q);
  assign imem_req_valid = (state_q == ST_REQ) && !halt && pc_aligned;
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign id_valid  = id_valid_q;
  assign id_pc     = id_pc_q;
  assign id_instr  = id_instr_q;
  assign id_fault  = id_fault_q;
  assign fetch_cnt = cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_BOOT;
      pc_q       <= RST_VECTOR;
      id_valid_q <= 1'b0;
      id_pc_q    <= '0;
      id_instr_q <= '0;
      id_fault_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      unique case (state_q)
        ST_BOOT: state_q <= ST_REQ;

        ST_REQ: begin
          if (redirect_valid) begin
            pc_q    <= redirect_pc;
            // A request that left this cycle now targets a stale PC.
            state_q <= req_fire ? ST_DROP : ST_REQ;
          end else if (req_fire) begin
            state_q <= ST_WAIT;
          end else if (!pc_aligned) begin
            state_q    <= ST_OUT;
            id_valid_q <= 1'b1;
            id_fault_q <= 1'b1;
            id_instr_q <= NOP_INSTR;
            id_pc_q    <= pc_q;
          end
        end

        ST_WAIT: begin
          if (redirect_valid) begin
            pc_q    <= redirect_pc;
            state_q <= imem_resp_valid ? ST_REQ : ST_DROP;
          end else if (imem_resp_valid) begin
            state_q    <= ST_OUT;
            id_valid_q <= 1'b1;
            id_fault_q <= imem_resp_err;
            id_instr_q <= imem_resp_err ? NOP_INSTR : imem_resp_data;
            id_pc_q    <= pc_q;
            pc_q       <= pc_q + XLEN'(4);
          end
        end

        ST_OUT: begin
          // A transfer coinciding with a redirect still counts as delivered.
          if (id_ready) cnt_q <= cnt_q + 32'd1;
          if (redirect_valid) pc_q <= redirect_pc;
          if (redirect_valid || id_ready) begin
            id_valid_q <= 1'b0;
            state_q    <= ST_REQ;
          end
        end

        ST_DROP: begin
          if (redirect_valid) pc_q <= redirect_pc;
          if (imem_resp_valid) state_q <= ST_REQ;
        end

        default: state_q <= ST_BOOT;
      endcase
    end
  end

`ifndef SYNTHESIS
  resp_only_when_expected: assert property (@(posedge clk) disable iff (rst)
    imem_resp_valid |-> (state_q == ST_WAIT || state_q == ST_DROP));
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed scenarios plus a randomized run scored against
// an instruction-stream model (sequential PCs from the latest redirect target).
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        imem_resp_err = 1'b0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic        id_fault;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        halt = 1'b0;
  logic [31:0] fetch_cnt;

  always #5 clk = ~clk;

  ifu_fetch #(.RST_VECTOR(32'h8000_0000), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .imem_resp_err(imem_resp_err),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_instr(id_instr),
    .id_fault(id_fault), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt(halt), .fetch_cnt(fetch_cnt)
  );

  localparam logic [31:0] NOP = 32'h0000_0013;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Memory model state
  bit          mem_pend = 0;
  logic [31:0] mem_addr = '0;
  int          mem_cnt = 0;
  int          mem_lat = 1;
  bit          mem_rand_lat = 0;
  bit          rand_err = 0;
  bit          err_en = 0;
  logic [31:0] err_addr = '0;
  bit          dbg_once = 0;
  bit          delivered = 0;

  // Per-cycle samples taken at the falling edge
  logic        s_req_valid, s_req_hs, s_id_valid, s_id_hs, s_id_fault, s_redir, s_halt, s_pend;
  logic [31:0] s_req_addr, s_id_pc, s_id_instr, s_redir_pc;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  function automatic bit mem_err(input logic [31:0] a);
    return a[7:2] == 6'h2A;
  endfunction

  task automatic tick();
    delivered = 0;
    if (mem_pend && mem_cnt == 0) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = dbg_once ? 32'hDEAD_BEEF : mem_data(mem_addr);
      imem_resp_err   = (err_en && mem_addr == err_addr) || (rand_err && mem_err(mem_addr));
      delivered = 1;
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
      imem_resp_err   = 1'b0;
    end
    @(negedge clk);
    s_req_valid = imem_req_valid;
    s_req_hs    = imem_req_valid && imem_req_ready;
    s_req_addr  = imem_req_addr;
    s_id_valid  = id_valid;
    s_id_hs     = id_valid && id_ready;
    s_id_pc     = id_pc;
    s_id_instr  = id_instr;
    s_id_fault  = id_fault;
    s_redir     = redirect_valid;
    s_redir_pc  = redirect_pc;
    s_halt      = halt;
    s_pend      = mem_pend;
    @(posedge clk);
    #1;
    if (delivered) begin
      mem_pend = 0;
      dbg_once = 0;
    end
    if (s_req_hs) begin
      mem_pend = 1;
      mem_addr = s_req_addr;
      mem_cnt  = mem_rand_lat ? int'($urandom_range(2, 0)) : mem_lat - 1;
    end else if (mem_pend && mem_cnt > 0) begin
      mem_cnt--;
    end
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect_valid = 1'b0; halt = 1'b0; id_ready = 1'b0; imem_req_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    mem_pend = 0; dbg_once = 0; err_en = 0; rand_err = 0; mem_rand_lat = 0; mem_lat = 1;
    cyc = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++; if (s_req_valid !== 1'b0) $display("FAIL reset_req_valid: got %b want 0", s_req_valid); else n_pass++;
    n_checks++; if (s_id_valid !== 1'b0) $display("FAIL reset_id_valid: got %b want 0", s_id_valid); else n_pass++;
    n_checks++; if (s_id_pc !== 32'h0) $display("FAIL reset_id_pc: got %h want 0", s_id_pc); else n_pass++;
    n_checks++; if (s_id_instr !== 32'h0) $display("FAIL reset_id_instr: got %h want 0", s_id_instr); else n_pass++;
    n_checks++; if (s_id_fault !== 1'b0) $display("FAIL reset_id_fault: got %b want 0", s_id_fault); else n_pass++;
    n_checks++; if (fetch_cnt !== 32'h0) $display("FAIL reset_fetch_cnt: got %0d want 0", fetch_cnt); else n_pass++;
  endtask

  task automatic test_sequential();
    int          vcyc[$];
    logic [31:0] addrs[$];
    logic [31:0] pcs[$];
    int          exp_c[3];
    logic [31:0] exp_a[3];
    exp_c = '{3, 6, 9};
    exp_a = '{32'h8000_0000, 32'h8000_0004, 32'h8000_0008};
    do_reset();
    id_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (s_id_valid) begin vcyc.push_back(c); pcs.push_back(s_id_pc); end
      if (s_req_hs) addrs.push_back(s_req_addr);
    end
    n_checks++; if (vcyc.size() != 3 || addrs.size() != 3)
      $display("FAIL seq_counts: valid cycles %0d requests %0d want 3 and 3", vcyc.size(), addrs.size());
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (i >= vcyc.size() || vcyc[i] != exp_c[i] || addrs[i] !== exp_a[i] || pcs[i] !== exp_a[i])
        $display("FAIL seq_item%0d: valid cycle %0d addr %h pc %h want cycle %0d addr/pc %h",
                 i, (i < vcyc.size()) ? vcyc[i] : -1, addrs[i], pcs[i], exp_c[i], exp_a[i]);
      else n_pass++;
    end
    n_checks++; if (fetch_cnt !== 32'd3) $display("FAIL seq_fetch_cnt: got %0d want 3", fetch_cnt); else n_pass++;
  endtask

  task automatic test_backpressure();
    bit got = 0;
    do_reset();
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      if (s_id_valid) got = 1;
    end
    n_checks++; if (!got) $display("FAIL bp_timeout: id_valid never seen, want within 10 cycles"); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (s_id_valid !== 1'b1 || s_id_pc !== 32'h8000_0000 || s_id_instr !== mem_data(32'h8000_0000) || s_req_valid !== 1'b0)
        $display("FAIL bp_hold%0d: valid %b pc %h instr %h req %b want 1 80000000 %h 0",
                 i, s_id_valid, s_id_pc, s_id_instr, s_req_valid, mem_data(32'h8000_0000));
      else n_pass++;
    end
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
    tick();
    n_checks++; if (s_req_valid !== 1'b1 || s_req_addr !== 32'h8000_0004)
      $display("FAIL bp_next_req: valid %b addr %h want 1 80000004", s_req_valid, s_req_addr);
    else n_pass++;
    n_checks++; if (fetch_cnt !== 32'd1) $display("FAIL bp_fetch_cnt: got %0d want 1", fetch_cnt); else n_pass++;
  endtask

  task automatic test_redirect_wait();
    bit got_hs = 0, got_req = 0, got_id = 0;
    do_reset();
    id_ready = 1'b1; mem_lat = 3; dbg_once = 1;
    for (int i = 0; i < 10 && !got_hs; i++) begin
      tick();
      if (s_req_hs) got_hs = 1;
    end
    redirect_valid = 1'b1; redirect_pc = 32'h8000_1000;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 20 && !got_id; i++) begin
      tick();
      if (s_req_hs && !got_req) begin
        got_req = 1;
        n_checks++; if (s_req_addr !== 32'h8000_1000)
          $display("FAIL rw_req_addr: got %h want 80001000", s_req_addr);
        else n_pass++;
      end
      if (s_id_valid) begin
        got_id = 1;
        n_checks++; if (s_id_pc !== 32'h8000_1000 || s_id_instr !== mem_data(32'h8000_1000))
          $display("FAIL rw_first_id: pc %h instr %h want 80001000 %h", s_id_pc, s_id_instr, mem_data(32'h8000_1000));
        else n_pass++;
      end
    end
    n_checks++; if (!got_hs || !got_req || !got_id)
      $display("FAIL rw_timeout: hs %b req %b id %b want 1 1 1", got_hs, got_req, got_id);
    else n_pass++;
  endtask

  task automatic test_misaligned();
    bit got = 0, req_seen = 0;
    do_reset();
    imem_req_ready = 1'b0;
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0102;
    tick();
    redirect_valid = 1'b0; imem_req_ready = 1'b1;
    for (int i = 0; i < 5 && !got; i++) begin
      tick();
      if (s_req_valid) req_seen = 1;
      if (s_id_valid) got = 1;
    end
    n_checks++; if (!got || req_seen) $display("FAIL mis_flow: id seen %b request seen %b want 1 0", got, req_seen); else n_pass++;
    n_checks++; if (s_id_fault !== 1'b1 || s_id_instr !== NOP || s_id_pc !== 32'h8000_0102)
      $display("FAIL mis_output: fault %b instr %h pc %h want 1 00000013 80000102", s_id_fault, s_id_instr, s_id_pc);
    else n_pass++;
  endtask

  task automatic test_resp_err();
    bit got = 0, got_req = 0;
    do_reset();
    id_ready = 1'b1; err_en = 1; err_addr = 32'h8000_0010; imem_req_ready = 1'b0;
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0010;
    tick();
    redirect_valid = 1'b0; imem_req_ready = 1'b1;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      if (s_id_valid) got = 1;
    end
    n_checks++; if (!got || s_id_fault !== 1'b1 || s_id_instr !== NOP || s_id_pc !== 32'h8000_0010)
      $display("FAIL err_output: seen %b fault %b instr %h pc %h want 1 1 00000013 80000010", got, s_id_fault, s_id_instr, s_id_pc);
    else n_pass++;
    for (int i = 0; i < 10 && !got_req; i++) begin
      tick();
      if (s_req_hs) got_req = 1;
    end
    n_checks++; if (!got_req || s_req_addr !== 32'h8000_0014)
      $display("FAIL err_next_req: seen %b addr %h want 1 80000014", got_req, s_req_addr);
    else n_pass++;
  endtask

  task automatic test_halt_rst();
    bit got_req = 0, got_id = 0;
    do_reset();
    halt = 1'b1; id_ready = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++; if (s_req_valid !== 1'b0) $display("FAIL halt_req%0d: got %b want 0", i, s_req_valid); else n_pass++;
    end
    halt = 1'b0; dbg_once = 1;
    tick();
    n_checks++; if (s_req_hs !== 1'b1 || s_req_addr !== 32'h8000_0000)
      $display("FAIL halt_resume: hs %b addr %h want 1 80000000", s_req_hs, s_req_addr);
    else n_pass++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mem_pend = 0;
    for (int i = 0; i < 12 && !got_id; i++) begin
      tick();
      if (s_req_hs && !got_req) begin
        got_req = 1;
        n_checks++; if (s_req_addr !== 32'h8000_0000) $display("FAIL rst_req_addr: got %h want 80000000", s_req_addr); else n_pass++;
      end
      if (s_id_valid) begin
        got_id = 1;
        n_checks++; if (s_id_pc !== 32'h8000_0000 || s_id_instr !== mem_data(32'h8000_0000))
          $display("FAIL rst_first_id: pc %h instr %h want 80000000 %h", s_id_pc, s_id_instr, mem_data(32'h8000_0000));
        else n_pass++;
      end
    end
    n_checks++; if (!got_req || !got_id) $display("FAIL rst_timeout: req %b id %b want 1 1", got_req, got_id); else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] exp_pc = 32'h8000_0000;
    logic [31:0] exp_instr;
    logic        exp_fault;
    logic [31:0] tgt;
    logic [15:0] r16;
    int          acc = 0;
    int          bad = 0;
    do_reset();
    rand_err = 1; mem_rand_lat = 1;
    tick();
    for (int i = 0; i < 3000; i++) begin
      id_ready       = ($urandom_range(3, 0) != 0);
      halt           = ($urandom_range(9, 0) == 0);
      imem_req_ready = ($urandom_range(9, 0) < 7);
      redirect_valid = ($urandom_range(19, 0) == 0);
      if (redirect_valid) begin
        r16 = 16'($urandom());
        tgt = {16'h8000, r16};
        if ($urandom_range(7, 0) != 0) tgt[1:0] = 2'b00;
        redirect_pc = tgt;
      end
      tick();
      if (s_req_valid) begin
        n_checks++;
        if (s_halt || s_req_addr[1:0] != 2'b00 || s_pend) begin
          if (bad < 10) $display("FAIL rnd_req_proto: halt %b addr %h outstanding %b want 0 aligned 0", s_halt, s_req_addr, s_pend);
          bad++;
        end else n_pass++;
      end
      if (s_id_hs) begin
        if (exp_pc[1:0] != 2'b00) begin
          exp_fault = 1'b1; exp_instr = NOP;
        end else begin
          exp_fault = mem_err(exp_pc);
          exp_instr = exp_fault ? NOP : mem_data(exp_pc);
        end
        n_checks++;
        if (s_id_pc !== exp_pc || s_id_instr !== exp_instr || s_id_fault !== exp_fault) begin
          if (bad < 10) $display("FAIL rnd_stream: pc %h instr %h fault %b want %h %h %b",
                                 s_id_pc, s_id_instr, s_id_fault, exp_pc, exp_instr, exp_fault);
          bad++;
        end else n_pass++;
        acc++;
        if (exp_pc[1:0] == 2'b00) exp_pc = exp_pc + 32'd4;
      end
      if (s_redir) exp_pc = s_redir_pc;
    end
    redirect_valid = 1'b0; halt = 1'b0; id_ready = 1'b0;
    n_checks++; if (fetch_cnt !== 32'(acc)) $display("FAIL rnd_fetch_cnt: got %0d want %0d", fetch_cnt, acc); else n_pass++;
    n_checks++; if (acc < 100) $display("FAIL rnd_progress: accepted %0d want at least 100", acc); else n_pass++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_wait();
    test_misaligned();
    test_resp_err();
    test_halt_rst();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
